// File: rtl/dstack_ctrl.sv
// ---------------------------------------------------------------------------
// dstack_ctrl - data (scratch) stack sequencing controller
//
// Owns the stack pointer and turns push / pop / peek requests from the
// instruction sequencer into single-cycle accesses on a single-port
// synchronous block RAM. Each RAM access and each pointer update takes its
// own cycle. One response pulse is produced per accepted command.
//
// Ports
//   CLK, RST_N           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_op               00 NOP, 01 PUSH, 10 POP, 11 PEEK
//   cmd_wdata            PUSH data
//   rsp_valid            one-cycle response pulse
//   rsp_err              overflow / underflow flag, qualifies rsp_valid
//   rsp_data             POP/PEEK result, holds last value otherwise
//   depth                current entry count
//   hwm                  high-water mark of depth since reset
//   mem_we/mem_re        RAM write / read enables (never both)
//   mem_addr, mem_wdata  RAM address / write data (address 0 when idle)
//   mem_rdata            RAM read data, valid the cycle after mem_re
//
// Build option
//   DSTACK_HWM_EN        when defined, hwm tracks max(depth); otherwise 0.
// ---------------------------------------------------------------------------
module dstack_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_wdata,
  output logic             cmd_ready,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_data,
  output logic [AW:0]      depth,
  output logic [AW:0]      hwm,
  output logic             mem_we,
  output logic             mem_re,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_D    = 1;
  localparam logic [AW-1:0] ONE_A    = 1;

  typedef enum logic [2:0] {IDLE, WR, RD, CAP, RESP} state_t;

  state_t           state_reg, state_next;
  logic [AW:0]      depth_reg, depth_next;
  logic [WIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic [WIDTH-1:0] wdata_reg, wdata_next;
  logic             err_reg, err_next;
  logic             pop_reg, pop_next;   // CAP decrements depth only for POP

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      depth_reg    <= '0;
      rsp_data_reg <= '0;
      wdata_reg    <= '0;
      err_reg      <= 1'b0;
      pop_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      depth_reg    <= depth_next;
      rsp_data_reg <= rsp_data_next;
      wdata_reg    <= wdata_next;
      err_reg      <= err_next;
      pop_reg      <= pop_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    depth_next    = depth_reg;
    rsp_data_next = rsp_data_reg;
    wdata_next    = wdata_reg;
    err_next      = err_reg;
    pop_next      = pop_reg;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          err_next = 1'b0;
          pop_next = 1'b0;
          case (cmd_op)
            OP_NOP: state_next = RESP;
            OP_PUSH: begin
              if (depth_reg == FULL_LVL) begin
                err_next   = 1'b1;
                state_next = RESP;
              end else begin
                wdata_next = cmd_wdata;
                state_next = WR;
              end
            end
            OP_POP, OP_PEEK: begin
              if (depth_reg == '0) begin
                err_next   = 1'b1;
                state_next = RESP;
              end else begin
                pop_next   = (cmd_op == OP_POP);
                state_next = RD;
              end
            end
            default: state_next = RESP;
          endcase
        end
      end
      WR: begin
        mem_we     = 1'b1;
        mem_addr   = depth_reg[AW-1:0];
        mem_wdata  = wdata_reg;
        depth_next = depth_reg + ONE_D;
        state_next = RESP;
      end
      RD: begin
        // depth >= 1 here, so the low AW bits of depth-1 are the top slot.
        mem_re     = 1'b1;
        mem_addr   = depth_reg[AW-1:0] - ONE_A;
        state_next = CAP;
      end
      CAP: begin
        rsp_data_next = mem_rdata;
        if (pop_reg) depth_next = depth_reg - ONE_D;
        state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Held low while reset is asserted; rises once RST_N is released.
  assign cmd_ready = RST_N && (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_err   = (state_reg == RESP) && err_reg;
  assign rsp_data  = rsp_data_reg;
  assign depth     = depth_reg;

`ifdef DSTACK_HWM_EN
  // Updated from depth_next so it moves on the same edge as depth.
  logic [AW:0] hwm_reg;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                  hwm_reg <= '0;
    else if (depth_next > hwm_reg) hwm_reg <= depth_next;
  end
  assign hwm = hwm_reg;
`else
  assign hwm = '0;
`endif

endmodule

// File: tb/tb_dstack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dstack_ctrl - self-checking bench for dstack_ctrl.
// A queue models the stack contents; a small synchronous RAM model serves
// the DUT's memory port. Directed steps plus a randomized command phase.
// ---------------------------------------------------------------------------
module tb_dstack_ctrl;
  localparam int WIDTH = 32;
  localparam int DEPTH = 128;
  localparam int AW    = 7;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_wdata = '0;
  logic             cmd_ready, rsp_valid, rsp_err;
  logic [WIDTH-1:0] rsp_data;
  logic [AW:0]      depth, hwm;
  logic             mem_we, mem_re;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata = '0;

  always #31 CLK = ~CLK;

  dstack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .depth(depth), .hwm(hwm),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port synchronous RAM with registered read.
  logic [WIDTH-1:0] ram [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // Reference model state
  logic [WIDTH-1:0] stk[$];
  logic [WIDTH-1:0] exp_rsp_data = '0;
  int               model_hwm = 0;
  int               n_checks = 0;
  int               n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_hwm();
`ifdef DSTACK_HWM_EN
    return model_hwm;
`else
    return 0;
`endif
  endfunction

  // One command through the handshake, observing every cycle to its response.
  task automatic do_cmd(input logic [1:0] op, input logic [WIDTH-1:0] wd);
    int exp_lat, exp_we_cyc, exp_re_cyc;
    logic exp_err;
    logic [AW-1:0] exp_addr;
    int rsp_cyc, we_cyc, re_cyc, we_n, re_n, both_n, addr_n;
    logic [AW-1:0] seen_addr;
    logic [WIDTH-1:0] seen_wdata;
    logic seen_err;
    logic [WIDTH-1:0] seen_data;
    logic [AW:0] seen_depth, seen_hwm;

    exp_err = 1'b0; exp_we_cyc = 0; exp_re_cyc = 0; exp_addr = '0; exp_lat = 1;
    case (op)
      OP_PUSH: begin
        if (stk.size() == DEPTH) exp_err = 1'b1;
        else begin
          exp_lat = 2; exp_we_cyc = 1; exp_addr = AW'(stk.size());
          stk.push_back(wd);
          if (stk.size() > model_hwm) model_hwm = stk.size();
        end
      end
      OP_POP, OP_PEEK: begin
        if (stk.size() == 0) exp_err = 1'b1;
        else begin
          exp_lat = 3; exp_re_cyc = 1; exp_addr = AW'(stk.size() - 1);
          if (op == OP_POP) exp_rsp_data = stk.pop_back();
          else              exp_rsp_data = stk[$];
        end
      end
      default: exp_lat = 1;
    endcase

    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = op; cmd_wdata = wd;
    check("cmd_ready", 64'(cmd_ready), 64'(1));
    @(posedge CLK); #1;
    cmd_valid = 1'b0; cmd_op = OP_NOP;

    rsp_cyc = 0; we_cyc = 0; re_cyc = 0; we_n = 0; re_n = 0; both_n = 0; addr_n = 0;
    seen_addr = '0; seen_wdata = '0; seen_err = 1'b0; seen_data = '0;
    seen_depth = '0; seen_hwm = '0;
    for (int k = 1; k <= 6; k++) begin
      if (mem_we) begin we_n++; we_cyc = k; seen_addr = mem_addr; seen_wdata = mem_wdata; end
      if (mem_re) begin re_n++; re_cyc = k; seen_addr = mem_addr; end
      if (mem_we && mem_re) both_n++;
      if (!mem_we && !mem_re && mem_addr != '0) addr_n++;
      if (rsp_valid) begin
        rsp_cyc = k; seen_err = rsp_err; seen_data = rsp_data;
        seen_depth = depth; seen_hwm = hwm;
        break;
      end
      @(posedge CLK); #1;
    end

    check("rsp_latency", 64'(rsp_cyc), 64'(exp_lat));
    check("rsp_err", 64'(seen_err), 64'(exp_err));
    check("rsp_data", 64'(seen_data), 64'(exp_rsp_data));
    check("depth", 64'(seen_depth), 64'(stk.size()));
    check("hwm", 64'(seen_hwm), 64'(exp_hwm()));
    check("we_cycle", 64'(we_cyc), 64'(exp_we_cyc));
    check("we_count", 64'(we_n), 64'(exp_we_cyc != 0));
    check("re_cycle", 64'(re_cyc), 64'(exp_re_cyc));
    check("re_count", 64'(re_n), 64'(exp_re_cyc != 0));
    check("we_re_both", 64'(both_n), 64'(0));
    check("idle_addr", 64'(addr_n), 64'(0));
    if (exp_we_cyc != 0 || exp_re_cyc != 0) check("mem_addr", 64'(seen_addr), 64'(exp_addr));
    if (exp_we_cyc != 0) check("mem_wdata", 64'(seen_wdata), 64'(wd));

    @(posedge CLK); #1;
    check("rsp_pulse", 64'(rsp_valid), 64'(0));
    $display("cmd op=%0d wd=%08h err=%0b data=%08h depth=%0d lat=%0d", op, wd, seen_err,
             seen_data, seen_depth, rsp_cyc);
  endtask

  initial begin
    int acc_i[$];
    int n_rsp;
    logic [1:0] rop;

    // Reset
    repeat (3) @(posedge CLK);
    #1;
    check("rst_depth", 64'(depth), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_we", 64'(mem_we), 64'(0));
    check("rst_re", 64'(mem_re), 64'(0));
    @(negedge CLK); RST_N = 1'b1;
    #1;
    check("rel_ready", 64'(cmd_ready), 64'(1));
    check("rel_hwm", 64'(hwm), 64'(0));
    check("rel_rsp_data", 64'(rsp_data), 64'(0));

    // Directed: single push, LIFO order, peek, underflow
    do_cmd(OP_PUSH, 32'hDEADBEEF);
    do_cmd(OP_POP, 32'h0);
    do_cmd(OP_PUSH, 32'd1);
    do_cmd(OP_PUSH, 32'd2);
    do_cmd(OP_PUSH, 32'd3);
    do_cmd(OP_PEEK, 32'h0);
    do_cmd(OP_POP, 32'h0);
    do_cmd(OP_POP, 32'h0);
    do_cmd(OP_POP, 32'h0);
    do_cmd(OP_POP, 32'h0);
    do_cmd(OP_PEEK, 32'h0);
    do_cmd(OP_NOP, 32'h0);

    // Randomized commands
    for (int i = 0; i < 120; i++) begin
      rop = 2'($urandom_range(0, 3));
      do_cmd(rop, $urandom);
    end

    // Fill to capacity, then overflow
    while (stk.size() < DEPTH) do_cmd(OP_PUSH, $urandom);
    do_cmd(OP_PUSH, 32'hBAD0BAD0);
    do_cmd(OP_PEEK, 32'h0);
    for (int i = 0; i < 4; i++) do_cmd(OP_POP, 32'h0);

    // Reset while a POP is in its capture cycle
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = OP_POP;
    @(posedge CLK); #1;
    cmd_valid = 1'b0; cmd_op = OP_NOP;
    check("rstcap_re", 64'(mem_re), 64'(1));
    @(posedge CLK); #1;
    RST_N = 1'b0;
    stk.delete(); exp_rsp_data = '0; model_hwm = 0;
    #1;
    check("rstcap_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rstcap_depth", 64'(depth), 64'(0));
    check("rstcap_hwm", 64'(hwm), 64'(0));
    check("rstcap_rsp_data", 64'(rsp_data), 64'(0));
    @(negedge CLK); RST_N = 1'b1;
    n_rsp = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      if (rsp_valid) n_rsp++;
    end
    check("rstcap_no_rsp", 64'(n_rsp), 64'(0));
    check("rstcap_ready", 64'(cmd_ready), 64'(1));

    // Back-to-back pushes with cmd_valid held high
    n_rsp = 0;
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = OP_PUSH;
    for (int i = 0; i < 22; i++) begin
      if (i > 0) @(negedge CLK);
      if (rsp_valid) n_rsp++;
      if (i >= 15) cmd_valid = 1'b0;
      else if (cmd_ready) begin
        cmd_wdata = $urandom;
        stk.push_back(cmd_wdata);
        if (stk.size() > model_hwm) model_hwm = stk.size();
        acc_i.push_back(i);
      end
    end
    check("b2b_accepts", 64'(acc_i.size()), 64'(5));
    check("b2b_rsps", 64'(n_rsp), 64'(acc_i.size()));
    for (int j = 1; j < acc_i.size(); j++)
      check("b2b_interval", 64'(acc_i[j] - acc_i[j-1]), 64'(3));
    #1;
    check("b2b_depth", 64'(depth), 64'(stk.size()));
    check("b2b_hwm", 64'(hwm), 64'(exp_hwm()));
    do_cmd(OP_POP, 32'h0);
    do_cmd(OP_PEEK, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dstack_ctrl.md
# dstack_ctrl

Sequencing controller for the CPU's data (scratch) stack. It owns the stack pointer and sequences push, pop and peek requests from the instruction sequencer onto a single-port synchronous block RAM. Each RAM access and each pointer update gets its own cycle, so the sequencer never touches RAM or pointer directly. It sits between the instruction-execute phases and the stack RAM instance.

## Interface
- WIDTH, 32, data word width
- DEPTH, 128, stack capacity in words
- AW, 7, RAM address width; 2^AW >= DEPTH required

- CLK  in  1  system clock (16 MHz)
- RST_N  in  1  asynchronous, active-low reset
- cmd_valid  in  1  sequencer presents a command
- cmd_op  in  2  00 NOP, 01 PUSH, 10 POP, 11 PEEK
- cmd_wdata  in  WIDTH  PUSH data
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- rsp_valid  out  1  one-cycle pulse, exactly one per accepted command
- rsp_err  out  1  qualifies rsp_valid: overflow or underflow
- rsp_data  out  WIDTH  POP/PEEK result; holds last value otherwise
- depth  out  AW+1  current entry count
- hwm  out  AW+1  high-water mark (see Configuration)
- mem_we  out  1  RAM write enable
- mem_re  out  1  RAM read enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  WIDTH  RAM write data
- mem_rdata  in  WIDTH  RAM read data, valid the cycle after mem_re

## Operation
- States: IDLE, WR, RD, CAP, RESP.
- cmd_ready is 1 only in IDLE. Commands are not backpressured at the response side; the sequencer always takes rsp_valid.
- IDLE transitions:
  - NOP goes to RESP.
  - PUSH with depth==DEPTH goes to RESP with the error flag set.
  - PUSH otherwise latches cmd_wdata and goes to WR.
  - POP or PEEK with depth==0 goes to RESP with the error flag set.
  - POP or PEEK otherwise goes to RD.
- WR: mem_we=1, mem_addr=depth, mem_wdata=latched data. Go to RESP; depth<=depth+1 on that edge.
- RD: mem_re=1, mem_addr=depth-1. Go to CAP.
- CAP: rsp_data<=mem_rdata. Go to RESP. For POP only, depth<=depth-1 on that edge.
- RESP: rsp_valid=1, rsp_err as flagged. Go to IDLE.
- Error commands never touch RAM and leave depth and rsp_data unchanged.
- cmd_valid outside IDLE is ignored; the requester holds the command until it is accepted.
- depth arithmetic is AW+1 bits and never wraps: guarded by the full/empty checks.
- mem_we and mem_re are never asserted together. mem_addr is 0 whenever both are low.

## Timing
- Accept edge is cycle T.
- NOP or error: rsp_valid at T+1.
- PUSH: mem_we at T+1. depth updates and rsp_valid at T+2.
- POP/PEEK: mem_re at T+1, rdata captured at end of T+2, rsp_valid and rsp_data at T+3. POP's depth updates at T+3.
- Next accept no earlier than the cycle after rsp_valid (IDLE at T+2 / T+3 / T+4).
- Reset (async, any state): state=IDLE, depth=0, hwm=0, rsp_data=0, and all strobes (cmd_ready excepted) 0. cmd_ready=1 once RST_N deasserts. An in-flight command is dropped with no rsp_valid. RAM contents are not cleared.

## Configuration
- DSTACK_HWM_EN defined: hwm registers max(depth) since reset. It updates on the same edge as depth, so it is never less than depth.
- DSTACK_HWM_EN undefined: hwm tied to 0 and no tracking logic is built. All other behaviour is identical.

## Test plan
- Reset, then PUSH 32'hDEADBEEF -> mem_we at T+1 with addr 0 and data DEADBEEF; rsp_valid at T+2 with err 0; depth=1.
- PUSH 1,2,3, then PEEK -> rsp_data=3 at T+3, depth stays 3. Then POP×3 -> 3,2,1, depth=0.
- POP on empty -> rsp_valid at T+1 with rsp_err=1, no mem_re, depth=0, rsp_data unchanged.
- Fill DEPTH=128 entries, then PUSH -> rsp_err=1 at T+1, no mem_we, depth=128. With DSTACK_HWM_EN, hwm=128.
- Assert RST_N low during CAP of a POP -> no rsp_valid, depth=0, cmd_ready=1 after release.
- Hold cmd_valid high with back-to-back PUSHes -> accepts exactly every 3 cycles; each accept yields one rsp_valid.
